// File: rtl/mcycle_unit.sv
// ============================================================================
//  Module      : mcycle_unit
//  Description : Iterative multiply/divide unit for the Execute stage. It uses
//                shift-add multiply and restoring divide, one bit per cycle.
//                Optional macro MCYCLE_EARLY_TERM_EN ends a MUL early once the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;        // MUL: running product; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] opa;        // MUL: shifted multiplicand; DIV: divisor in low half
    logic [WIDTH-1:0]   opb;        // MUL: remaining multiplier bits
    logic [WIDTH-1:0]   dividend;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;
    logic               done_q;

    logic               accept;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;
    logic               last_iter;

    assign accept = Start && (state != S_COMPUTE);
    assign Busy   = (Start && ((state == S_IDLE) || (state == S_DONE))) || (state == S_COMPUTE);
    assign Done   = done_q;

    // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
    assign sign1 = MCycleOp[0] & Operand1[WIDTH-1];
    assign sign2 = MCycleOp[0] & Operand2[WIDTH-1];
    assign mag1  = sign1 ? (-Operand1) : Operand1;
    assign mag2  = sign2 ? (-Operand2) : Operand2;

    assign mul_next = acc + (opb[0] ? opa : '0);
    assign mul_prod = neg_main ? (-mul_next) : mul_next;

    assign div_shift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge       = div_shift >= {1'b0, opa[WIDTH-1:0]};
    assign div_diff     = div_shift[WIDTH-1:0] - opa[WIDTH-1:0];
    assign div_rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_quo_next = {acc[WIDTH-2:0], div_ge};

    assign quo_final = div_zero ? '1 : (neg_main ? (-div_quo_next) : div_quo_next);
    assign rem_final = div_zero ? dividend : (neg_rem ? (-div_rem_next) : div_rem_next);

`ifdef MCYCLE_EARLY_TERM_EN
    assign last_iter = (count == LAST_COUNT) || (!is_div && (opb[WIDTH-1:1] == '0));
`else
    assign last_iter = (count == LAST_COUNT);
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            dividend <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            Result1  <= '0;
            Result2  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state    <= S_COMPUTE;
                        count    <= '0;
                        is_div   <= MCycleOp[1];
                        neg_main <= sign1 ^ sign2;
                        neg_rem  <= sign1;
                        div_zero <= MCycleOp[1] && (Operand2 == '0);
                        dividend <= Operand1;
                        if (MCycleOp[1]) begin
                            acc <= {{WIDTH{1'b0}}, mag1};
                            opa <= {{WIDTH{1'b0}}, mag2};
                            opb <= '0;
                        end else begin
                            acc <= '0;
                            opa <= {{WIDTH{1'b0}}, mag1};
                            opb <= mag2;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        acc <= {div_rem_next, div_quo_next};
                    end else begin
                        acc <= mul_next;
                        opa <= {opa[2*WIDTH-2:0], 1'b0};
                        opb <= opb >> 1;
                    end
                    if (last_iter) begin
                        state   <= S_DONE;
                        done_q  <= 1'b1;
                        Result1 <= is_div ? quo_final : mul_prod[WIDTH-1:0];
                        Result2 <= is_div ? rem_final : mul_prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
